// File: rtl/control_sequencer.sv
// control_sequencer: hardwired timing/control unit for a basic 16-bit accumulator machine.
// Define IND_ADDR_EN to enable the indirect-address fetch in T3 (otherwise I is ignored).
module control_sequencer #(
    parameter bit AUTO_RUN = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] ir,
    input  logic [15:0] ac,
    input  logic [15:0] dr,
    input  logic        start,
    output logic        reset_ar,
    output logic        reset_pc,
    output logic        reset_dr,
    output logic        reset_tr,
    output logic        reset_ac,
    output logic        write_ar,
    output logic        write_pc,
    output logic        write_dr,
    output logic        write_tr,
    output logic        write_ir,
    output logic        write_ac,
    output logic        increment_ar,
    output logic        increment_pc,
    output logic        increment_dr,
    output logic        increment_tr,
    output logic        increment_ac,
    output logic        read_ar,
    output logic        read_pc,
    output logic        read_dr,
    output logic        read_tr,
    output logic        read_ir,
    output logic        read_ac,
    output logic        memory_read,
    output logic        memory_write,
    output logic [2:0]  alu_op,
    output logic        halted,
    output logic [3:0]  seq_state
);
    typedef enum logic [3:0] {
        S_INIT = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_HALT = 4'd8
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  op;
    logic [11:0] code;
    logic        is_reg;
    logic        indirect;

    assign op     = ir[14:12];
    assign code   = ir[11:0];
    assign is_reg = op == 3'd7;
`ifdef IND_ADDR_EN
    assign indirect = ir[15];
`else
    assign indirect = ir[15] & 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_INIT;
        else          state_q <= state_d;
    end

    // Encodings 9..15 are unreachable; any of them falls back to INIT.
    always_comb begin
        state_d = S_INIT;
        case (state_q)
            S_INIT:  state_d = AUTO_RUN ? S_T0 : S_HALT;
            S_T0:    state_d = S_T1;
            S_T1:    state_d = S_T2;
            S_T2:    state_d = S_T3;
            S_T3:    state_d = is_reg ? (code == 12'h001 ? S_HALT : S_T0) : S_T4;
            S_T4:    state_d = (op == 3'd3 || op == 3'd4) ? S_T0 : S_T5;
            S_T5:    state_d = op == 3'd6 ? S_T6 : S_T0;
            S_T6:    state_d = S_T0;
            S_HALT:  state_d = start ? S_T0 : S_HALT;
            default: state_d = S_INIT;
        endcase
    end

    // Outputs decode the current state; INIT's clears are gated so reset holds everything low.
    always_comb begin
        {reset_ar, reset_pc, reset_dr, reset_tr, reset_ac} = '0;
        {write_ar, write_pc, write_dr, write_tr, write_ir, write_ac} = '0;
        {increment_ar, increment_pc, increment_dr, increment_tr, increment_ac} = '0;
        {read_ar, read_pc, read_dr, read_tr, read_ir, read_ac, memory_read} = '0;
        memory_write = 1'b0;
        alu_op       = 3'b000;
        case (state_q)
            S_INIT: {reset_ar, reset_pc, reset_dr, reset_tr, reset_ac} = {5{reset_n}};
            S_T0: begin
                read_pc  = 1'b1;
                write_ar = 1'b1;
            end
            S_T1: begin
                memory_read  = 1'b1;
                write_ir     = 1'b1;
                increment_pc = 1'b1;
            end
            S_T2: begin
                read_ir  = 1'b1;
                write_ar = 1'b1;
            end
            S_T3: begin
                if (is_reg) begin
                    reset_ac     = code == 12'h800;
                    write_ac     = code == 12'h200;
                    alu_op       = code == 12'h200 ? 3'b011 : 3'b000;
                    increment_ac = code == 12'h020;
                    increment_pc = (code == 12'h010 && !ac[15]) ||
                                   (code == 12'h008 && ac[15]) ||
                                   (code == 12'h004 && ac == 16'h0000);
                end else begin
                    memory_read = indirect;
                    write_ar    = indirect;
                end
            end
            S_T4: begin
                case (op)
                    3'd0, 3'd1, 3'd2, 3'd6: begin
                        memory_read = 1'b1;
                        write_dr    = 1'b1;
                    end
                    3'd3: begin
                        read_ac      = 1'b1;
                        memory_write = 1'b1;
                    end
                    3'd4: begin
                        read_ar  = 1'b1;
                        write_pc = 1'b1;
                    end
                    3'd5: begin
                        read_pc      = 1'b1;
                        memory_write = 1'b1;
                        increment_ar = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                case (op)
                    3'd0, 3'd1, 3'd2: begin
                        write_ac = 1'b1;
                        alu_op   = op == 3'd0 ? 3'b001 : op == 3'd1 ? 3'b010 : 3'b000;
                    end
                    3'd5: begin
                        read_ar  = 1'b1;
                        write_pc = 1'b1;
                    end
                    3'd6: increment_dr = 1'b1;
                    default: ;
                endcase
            end
            S_T6: begin
                read_dr      = 1'b1;
                memory_write = 1'b1;
                increment_pc = dr == 16'h0000;
            end
            default: ;
        endcase
    end

    assign halted    = state_q == S_HALT;
    assign seq_state = state_q;
endmodule
